bcd_scan_display: RTL and testbench
===================================

# bcd_scan_display

Consumer end of the BCD counter chain. It snapshots a bus of cascaded BCD digits on a load strobe and time-multiplexes them onto a common-anode multi-digit seven-segment display. The block handles leading-zero blanking, decimal points, ghosting guard time and invalid-code marking. It sits between the counter digits and the board display pins.

## Interface
- DIGITS, 4: number of display digits (1..8); digit 0 is least significant
- SCAN_DIV, 50000: clock cycles each digit is selected (≥ 2)
- GUARD, 1: cycles at the start of each digit slot with all anodes off (0 ≤ GUARD < SCAN_DIV)
- BLANK_LEADING, 1: 1 enables leading-zero blanking, 0 shows all digits

- clk  in  1  single system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- load  in  1  snapshot request; acted on at rising edge (0→1) only
- bcd  in  4*DIGITS  digit i on bcd[4i+3:4i]
- dp_en  in  DIGITS  decimal point request per digit
- an  out  DIGITS  anode select, active-low, registered
- seg  out  7  {g,f,e,d,c,b,a}, active-low, registered
- dp  out  1  decimal point, active-low, registered

## Operation
- Edge detect: load_q holds the previous load value. A load edge is load==1 && load_q==0. On that clock, shadow_bcd <= bcd and shadow_dp <= dp_en. Level-held load captures once only.
- Prescaler pcnt counts 0..SCAN_DIV-1 and wraps. When pcnt==SCAN_DIV-1, idx advances, wrapping DIGITS-1 → 0.
- Per-cycle output register, computed from current idx, pcnt and shadow:
  - Guard: if pcnt < GUARD, then an = all 1, seg = 7'h7F, dp = 1.
  - Otherwise an = ~(1 << idx), and seg/dp come from digit idx.
- Decode (active-low), by code:
  - 0 → 1000000
  - 1 → 1111001
  - 2 → 0100100
  - 3 → 0110000
  - 4 → 0011001
  - 5 → 0010010
  - 6 → 0000010
  - 7 → 1111000
  - 8 → 0000000
  - 9 → 0010000
  - 10..15 → 0111111 (g only, "-")
- Blanking (BLANK_LEADING=1): digit i is blank when every digit j ≥ i has code 0 and shadow_dp[j]==0, and i ≠ 0.
  - A blank digit outputs seg = 7'h7F. Its anode is still driven.
  - Digit 0 is never blanked.
  - A set dp stops blanking at and below that digit, so "0.5" shows its 0.
- dp = ~shadow_dp[idx] outside guard.

## Timing
- Reset values:
  - pcnt=0, idx=0, load_q=0
  - shadow_bcd=0, shadow_dp=0
  - an=all 1, seg=7'h7F, dp=1
- First cycle after reset release has pcnt=0. Outputs reflect it one clock later (registered). With GUARD≥1 the display stays dark through the first GUARD output cycles.
- Output latency: one clock from (idx, pcnt, shadow) to pins. A load edge at clock N updates the shadow at N. The new value appears on the pins at clock N+1 if the digit is selected and outside guard.
- Each digit is lit for SCAN_DIV-GUARD cycles per frame. Frame period is DIGITS*SCAN_DIV cycles.
- Load during the active slot of a digit changes that digit's segments mid-slot. This is allowed; no tearing across digits, since all digits come from a single shadow.
- Simultaneous load edge and idx wrap: both take effect on the same clock, with no priority interaction.
- Reset asserted mid-frame: outputs go to reset values asynchronously, without waiting for clk. Shadow is lost.
- An invalid BCD code (>9) counts as nonzero for blanking.

## Test plan
(DIGITS=4, SCAN_DIV=4, GUARD=1, BLANK_LEADING=1 unless noted)
- Reset release with no load → all digits blank except digit 0:
  - digit 0 slot: an=1110, seg=1000000
  - digits 1..3 slots: an active, seg=7F
  - guard cycles: an=1111
- Load bcd=16'h1234 with dp_en=0 → slots show 4,3,2,1:
  - seg 0011001, 0110000, 0100100, 1111001 on an=1110, 1101, 1011, 0111
  - each for 3 cycles, preceded by 1 dark cycle
- Load bcd=16'h0005 with dp_en=4'b0010 → digit 0 shows 5, digit 1 shows 0 with dp=0, digits 2..3 blank. Repeat with BLANK_LEADING=0 → digits 2..3 show 1000000.
- Hold load high for 20 cycles while bcd changes from 16'h1111 to 16'h2222 → display keeps 1111. Drop load and raise it again → display shows 2222 starting one clock after the edge.
- Load bcd=16'h0A00 → digit 2 seg=0111111, digit 1 seg=1000000 (not blanked), digit 3 blank.
- Assert reset mid-slot (pcnt=2, idx=2) → an=1111, seg=7F, dp=1 immediately. After release, scanning restarts at idx=0 and shadow is zero.

Source files
------------

// File: rtl/bcd_scan_display.sv
// bcd_scan_display: snapshots a bus of cascaded BCD digits on a load edge and
// time-multiplexes them onto a common-anode seven-segment display.
// The block applies leading-zero blanking, drives decimal points, inserts a
// per-slot ghosting guard and shows invalid codes as "-".
module bcd_scan_display #(
    parameter int DIGITS        = 4,
    parameter int SCAN_DIV      = 50000,
    parameter int GUARD         = 1,
    parameter int BLANK_LEADING = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   bcd,
    input  logic [DIGITS-1:0]     dp_en,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int PCNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low segment pattern {g,f,e,d,c,b,a}; codes above 9 show "-".
    function automatic logic [6:0] decode(input logic [3:0] code);
        case (code)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

    logic                  load_q, load_d;
    logic [4*DIGITS-1:0]   shadow_bcd_q, shadow_bcd_d;
    logic [DIGITS-1:0]     shadow_dp_q, shadow_dp_d;
    logic [PCNT_W-1:0]     pcnt_q, pcnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;

    logic [DIGITS-1:0]     blank;
    logic                  run_zero;
    logic [3:0]            cur_code;
    logic                  in_guard;

    // Load edge capture and scan position (prescaler plus digit index).
    always_comb begin
        load_d       = load;
        shadow_bcd_d = shadow_bcd_q;
        shadow_dp_d  = shadow_dp_q;
        pcnt_d       = pcnt_q + PCNT_W'(1);
        idx_d        = idx_q;
        if (load && !load_q) begin
            shadow_bcd_d = bcd;
            shadow_dp_d  = dp_en;
        end
        if (pcnt_q == PCNT_W'(SCAN_DIV - 1)) begin
            pcnt_d = '0;
            idx_d  = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // A digit is blank while it and every digit above it are zero with no dp.
    always_comb begin
        // NOTE: run_zero is a running AND down the digits, so it must use
        // blocking assignments here; each iteration reads the previous value.
        run_zero = 1'b1;
        blank    = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run_zero = run_zero && (shadow_bcd_q[4*i +: 4] == 4'd0) && !shadow_dp_q[i];
            blank[i] = (BLANK_LEADING != 0) && (i != 0) && run_zero;
        end
    end

    // Next output pins from the current slot, position and shadow.
    always_comb begin
        cur_code = shadow_bcd_q[4*int'(idx_q) +: 4];
        in_guard = (int'(pcnt_q) < GUARD);
        an_d     = '1;
        seg_d    = SEG_OFF;
        dp_d     = 1'b1;
        if (!in_guard) begin
            an_d  = ~(DIGITS'(1) << idx_q);
            seg_d = blank[idx_q] ? SEG_OFF : decode(cur_code);
            dp_d  = ~shadow_dp_q[idx_q];
        end
    end

    // State and registered pins; reset darkens the display immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_q       <= 1'b0;
            shadow_bcd_q <= '0;
            shadow_dp_q  <= '0;
            pcnt_q       <= '0;
            idx_q        <= '0;
            an_q         <= '1;
            seg_q        <= SEG_OFF;
            dp_q         <= 1'b1;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            load_q       <= load_d;
            shadow_bcd_q <= shadow_bcd_d;
            shadow_dp_q  <= shadow_dp_d;
            pcnt_q       <= pcnt_d;
            idx_q        <= idx_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display with DIGITS=4, SCAN_DIV=4, GUARD=1.
// Two instances share stimulus: one with leading-zero blanking, one without.
module tb_bcd_scan_display;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;
    localparam int GUARD    = 1;
    localparam int FRAME    = DIGITS * SCAN_DIV;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] SD = 7'b0111111;
    localparam logic [6:0] SB = 7'h7F;
    localparam logic [11:0] DARK = {4'hF, 7'h7F, 1'b1};

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0;
    logic [15:0] bcd = '0;
    logic [3:0]  dp_en = '0;
    logic [3:0]  an_a, an_b;
    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    bcd_scan_display #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .GUARD(GUARD), .BLANK_LEADING(1)) dut_a (
        .clk(clk), .reset(reset), .load(load), .bcd(bcd), .dp_en(dp_en),
        .an(an_a), .seg(seg_a), .dp(dp_a)
    );

    bcd_scan_display #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .GUARD(GUARD), .BLANK_LEADING(0)) dut_b (
        .clk(clk), .reset(reset), .load(load), .bcd(bcd), .dp_en(dp_en),
        .an(an_b), .seg(seg_b), .dp(dp_b)
    );

    // Clock edges since reset release; after edge k the pins show slot k-1.
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got {an,seg,dp}=%b_%b_%b expected %b_%b_%b",
                     tag, got[11:8], got[7:1], got[0], exp[11:8], exp[7:1], exp[0]);
        end
    endtask

    // Advance to the negedge where the pins show frame slot ph.
    task automatic wait_phase(input int ph);
        logic found;
        found = 1'b0;
        for (int t = 0; t < 4 * FRAME; t++) begin
            @(negedge clk);
            if (cyc >= 1 && ((cyc - 1) % FRAME) == ph) begin
                found = 1'b1;
                break;
            end
        end
        check($sformatf("align_ph%0d", ph), {11'b0, found}, 12'h001);
    endtask

    function automatic logic [11:0] expect_pins(input int p, input logic [27:0] segs,
                                                input logic [3:0] dpx);
        int idx, pc;
        idx = p / SCAN_DIV;
        pc  = p % SCAN_DIV;
        if (pc < GUARD) return DARK;
        return {~(4'b0001 << idx), segs[idx*7 +: 7], ~dpx[idx]};
    endfunction

    // Check one whole frame on both instances; segs packed {d3,d2,d1,d0}.
    task automatic check_frame(input string tag, input logic [27:0] segs_a,
                               input logic [27:0] segs_b, input logic [3:0] dpx);
        wait_phase(0);
        for (int p = 0; p < FRAME; p++) begin
            if (p != 0) @(negedge clk);
            check($sformatf("%s_bl_p%0d", tag, p), {an_a, seg_a, dp_a}, expect_pins(p, segs_a, dpx));
            check($sformatf("%s_nb_p%0d", tag, p), {an_b, seg_b, dp_b}, expect_pins(p, segs_b, dpx));
        end
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
        @(negedge clk);
        bcd   = v;
        dp_en = d;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_a", {an_a, seg_a, dp_a}, DARK);
        check("reset_b", {an_b, seg_b, dp_b}, DARK);
        reset = 1'b1;

        // Empty shadow: only digit 0 lit with blanking.
        check_frame("empty", {SB, SB, SB, S0}, {S0, S0, S0, S0}, 4'b0000);

        pulse_load(16'h1234, 4'b0000);
        check_frame("h1234", {S1, S2, S3, S4}, {S1, S2, S3, S4}, 4'b0000);

        // A set dp on digit 1 keeps its zero visible.
        pulse_load(16'h0005, 4'b0010);
        check_frame("h0005dp", {SB, SB, S0, S5}, {S0, S0, S0, S5}, 4'b0010);

        // Level-held load captures once only.
        @(negedge clk);
        bcd   = 16'h1111;
        dp_en = 4'b0000;
        load  = 1'b1;
        repeat (3) @(negedge clk);
        bcd = 16'h2222;
        repeat (17) @(negedge clk);
        load = 1'b0;
        check_frame("hold1111", {S1, S1, S1, S1}, {S1, S1, S1, S1}, 4'b0000);

        // New edge: pins change exactly one clock after the capturing edge.
        wait_phase(0);
        load = 1'b1;
        @(negedge clk);
        check("edge_old_a", {an_a, seg_a, dp_a}, {4'b1110, S1, 1'b1});
        @(negedge clk);
        check("edge_new_a", {an_a, seg_a, dp_a}, {4'b1110, S2, 1'b1});
        check("edge_new_b", {an_b, seg_b, dp_b}, {4'b1110, S2, 1'b1});
        check_frame("h2222", {S2, S2, S2, S2}, {S2, S2, S2, S2}, 4'b0000);
        load = 1'b0;

        // Invalid code counts as nonzero for blanking.
        pulse_load(16'h0A00, 4'b0000);
        check_frame("h0A00", {SB, SD, S0, S0}, {S0, SD, S0, S0}, 4'b0000);

        // Asynchronous reset mid-slot (internal pcnt=2, idx=2).
        wait_phase(9);
        check("pre_rst_a", {an_a, seg_a, dp_a}, {4'b1011, SD, 1'b1});
        reset = 1'b0;
        #1;
        check("async_rst_a", {an_a, seg_a, dp_a}, DARK);
        check("async_rst_b", {an_b, seg_b, dp_b}, DARK);
        repeat (2) @(negedge clk);
        check("held_rst_a", {an_a, seg_a, dp_a}, DARK);
        reset = 1'b1;
        check_frame("post_rst", {SB, SB, SB, S0}, {S0, S0, S0, S0}, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
